// File: rtl/wavelet_result_serializer.sv
// rtl/wavelet_result_serializer.sv - buffers wide result words and re-emits them as narrow valid/ready beats
// Level counter (not pointer equality) distinguishes full from empty.
module wavelet_result_serializer #(
  parameter int DATA_WIDTH = 16,
  parameter int LANES      = 16,
  parameter int OUT_LANES  = 4,
  parameter int FIFO_DEPTH = 8,
  parameter int PKT_WORDS  = 64
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              clear,
  input  logic                              in_valid,
  input  logic [DATA_WIDTH*LANES-1:0]       in_data,
  output logic                              m_valid,
  input  logic                              m_ready,
  output logic [DATA_WIDTH*OUT_LANES-1:0]   m_data,
  output logic                              m_last,
  output logic                              overflow,
  output logic [$clog2(FIFO_DEPTH):0]       fifo_level
);

  localparam int IW    = DATA_WIDTH * LANES;
  localparam int OW    = DATA_WIDTH * OUT_LANES;
  localparam int BEATS = LANES / OUT_LANES;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int PW    = $clog2(FIFO_DEPTH);
  localparam int LW    = PW + 1;
  localparam int WCW   = (PKT_WORDS > 1) ? $clog2(PKT_WORDS) : 1;

  localparam logic [BW-1:0]  LAST_BEAT = BW'(BEATS - 1);
  localparam logic [WCW-1:0] LAST_WORD = WCW'(PKT_WORDS - 1);
  localparam logic [LW-1:0]  FULL      = LW'(FIFO_DEPTH);

  logic [IW-1:0]  mem [FIFO_DEPTH];
  logic [PW-1:0]  wptr, rptr;
  logic [LW-1:0]  level;
  logic [BW-1:0]  bcnt;
  logic [WCW-1:0] wcnt;
  logic [IW-1:0]  head;
  logic [OW-1:0]  slice;
  logic           handshake, final_beat, pop, push;

  assign head       = mem[rptr];
  assign m_valid    = (level != '0);
  assign handshake  = m_valid & m_ready;
  assign final_beat = (bcnt == LAST_BEAT);
  assign pop        = handshake & final_beat;
  // A full FIFO still accepts a word when the head leaves on this same edge.
  assign push       = in_valid & ~clear & ((level != FULL) | pop);
  assign fifo_level = level;

  always_comb begin
    slice = '0;
    for (int b = 0; b < BEATS; b++) begin
      if (bcnt == BW'(b)) slice = head[b*OW +: OW];
    end
  end

  assign m_data = m_valid ? slice : '0;
  assign m_last = m_valid & final_beat & (wcnt == LAST_WORD);

  // Storage is never read while empty, so it needs no reset.
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= in_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr     <= '0;
      rptr     <= '0;
      level    <= '0;
      bcnt     <= '0;
      wcnt     <= '0;
      overflow <= 1'b0;
    end else if (clear) begin
      wptr     <= '0;
      rptr     <= '0;
      level    <= '0;
      bcnt     <= '0;
      wcnt     <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wptr <= wptr + PW'(1);
      if (pop)  rptr <= rptr + PW'(1);
      case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
      if (handshake) bcnt <= final_beat ? '0 : bcnt + BW'(1);
      if (pop)       wcnt <= (wcnt == LAST_WORD) ? '0 : wcnt + WCW'(1);
      if (in_valid && !push) overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_wavelet_result_serializer.sv
// tb/tb_wavelet_result_serializer.sv - directed self-checking bench for wavelet_result_serializer
module tb_wavelet_result_serializer;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         clear;
  logic         in_valid;
  logic [255:0] in_data;
  logic         m_valid;
  logic         m_ready;
  logic [63:0]  m_data;
  logic         m_last;
  logic         overflow;
  logic [3:0]   fifo_level;

  int total = 0;
  int bad   = 0;

  wavelet_result_serializer dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_data(in_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .overflow(overflow), .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] mkword(input logic [15:0] base);
    logic [255:0] w;
    for (int i = 0; i < 16; i++) w[16*i +: 16] = base + 16'(i);
    return w;
  endfunction

  function automatic logic [63:0] beatof(input logic [255:0] w, input int b);
    return w[64*b +: 64];
  endfunction

  // 64 words, one every 4 cycles, m_ready held high; word k has lanes base+16k+i.
  task automatic run_packet(input logic [15:0] base, output int last_idx, output int last_cnt,
                            output int maxlvl, output int errs, output int beats);
    logic [63:0] exp;
    last_idx = -1; last_cnt = 0; maxlvl = 0; errs = 0; beats = 0;
    m_ready = 1'b1;
    for (int cyc = 0; cyc < 64*4 + 8; cyc++) begin
      if (int'(fifo_level) > maxlvl) maxlvl = int'(fifo_level);
      if (m_valid) begin
        exp = beatof(mkword(base + 16'((beats/4)*16)), beats % 4);
        if (m_data !== exp) errs++;
        beats++;
        if (m_last) begin
          last_cnt++;
          last_idx = beats;
        end
      end
      in_valid = (cyc % 4 == 0) && (cyc / 4 < 64);
      in_data  = mkword(base + 16'((cyc/4)*16));
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  initial begin
    int li, lc, ml, er, bt, hs, cyc, serr;
    logic [63:0] held;

    rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; in_data = '0; m_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_m_valid", 64'(m_valid), 64'd0);
    chk("rst_m_data", m_data, 64'd0);
    chk("rst_m_last", 64'(m_last), 64'd0);
    chk("rst_overflow", 64'(overflow), 64'd0);
    chk("rst_level", 64'(fifo_level), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // single word, 4 beats
    m_ready = 1'b1; in_valid = 1'b1; in_data = mkword(16'h1000);
    chk("t1_pre_valid", 64'(m_valid), 64'd0);
    @(negedge clk);
    in_valid = 1'b0;
    chk("t1_valid", 64'(m_valid), 64'd1);
    chk("t1_beat0", m_data, 64'h1003_1002_1001_1000);
    chk("t1_last0", 64'(m_last), 64'd0);
    @(negedge clk);
    chk("t1_beat1", m_data, 64'h1007_1006_1005_1004);
    @(negedge clk);
    chk("t1_beat2", m_data, 64'h100B_100A_1009_1008);
    @(negedge clk);
    chk("t1_beat3", m_data, 64'h100F_100E_100D_100C);
    chk("t1_last3", 64'(m_last), 64'd0);
    @(negedge clk);
    chk("t1_done", 64'(m_valid), 64'd0);

    // full packet at 1-in-4 word rate
    clear = 1'b1; @(negedge clk); clear = 1'b0;
    run_packet(16'h0100, li, lc, ml, er, bt);
    chk("t2_beats", 64'(bt), 64'd256);
    chk("t2_last_idx", 64'(li), 64'd256);
    chk("t2_last_cnt", 64'(lc), 64'd1);
    chk("t2_maxlvl", 64'(ml), 64'd1);
    chk("t2_data_errs", 64'(er), 64'd0);
    chk("t2_overflow", 64'(overflow), 64'd0);

    // stall: 9 words into a depth-8 FIFO
    m_ready = 1'b0; serr = 0;
    for (int w = 0; w < 9; w++) begin
      in_valid = 1'b1; in_data = mkword(16'h2000 + 16'(w*16));
      @(negedge clk);
      if (m_data !== beatof(mkword(16'h2000), 0)) serr++;
      if (w == 7) chk("t3_ovf_before9", 64'(overflow), 64'd0);
    end
    in_valid = 1'b0;
    @(negedge clk);
    if (m_data !== beatof(mkword(16'h2000), 0)) serr++;
    chk("t3_level", 64'(fifo_level), 64'd8);
    chk("t3_overflow", 64'(overflow), 64'd1);
    chk("t3_stall_stable", 64'(serr), 64'd0);
    m_ready = 1'b1; er = 0;
    for (int k = 0; k < 32; k++) begin
      if (!m_valid || m_data !== beatof(mkword(16'h2000 + 16'((k/4)*16)), k % 4)) er++;
      @(negedge clk);
    end
    chk("t3_drain_errs", 64'(er), 64'd0);
    chk("t3_word9_absent", 64'(m_valid), 64'd0);
    chk("t3_ovf_sticky", 64'(overflow), 64'd1);

    // full FIFO + final-beat pop + push
    clear = 1'b1; @(negedge clk); clear = 1'b0;
    chk("t4_clear_ovf", 64'(overflow), 64'd0);
    m_ready = 1'b0;
    for (int w = 0; w < 8; w++) begin
      in_valid = 1'b1; in_data = mkword(16'h3000 + 16'(w*16));
      @(negedge clk);
    end
    in_valid = 1'b0; m_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("t4_head_beat3", m_data, beatof(mkword(16'h3000), 3));
    in_valid = 1'b1; in_data = mkword(16'h3080);
    @(negedge clk);
    in_valid = 1'b0; m_ready = 1'b0;
    chk("t4_level", 64'(fifo_level), 64'd8);
    chk("t4_overflow", 64'(overflow), 64'd0);
    chk("t4_next_head", m_data, beatof(mkword(16'h3010), 0));
    m_ready = 1'b1;
    repeat (28) @(negedge clk);
    chk("t4_tail_word", m_data, beatof(mkword(16'h3080), 0));
    repeat (4) @(negedge clk);

    // mid-packet clear with coincident in_valid
    clear = 1'b1; @(negedge clk); clear = 1'b0;
    m_ready = 1'b1; hs = 0; cyc = 0;
    while (hs < 14 && cyc < 100) begin
      in_valid = (cyc < 4);
      in_data  = mkword(16'h4000 + 16'(cyc*16));
      if (m_valid && m_ready) hs++;
      @(negedge clk);
      cyc++;
    end
    in_valid = 1'b0;
    chk("t5_hs_count", 64'(hs), 64'd14);
    chk("t5_pre_clear", m_data, beatof(mkword(16'h4030), 2));
    clear = 1'b1; in_valid = 1'b1; in_data = mkword(16'h4F00);
    @(negedge clk);
    clear = 1'b0; in_valid = 1'b0;
    chk("t5_valid", 64'(m_valid), 64'd0);
    chk("t5_level", 64'(fifo_level), 64'd0);
    chk("t5_overflow", 64'(overflow), 64'd0);
    run_packet(16'h0500, li, lc, ml, er, bt);
    chk("t5_last_idx", 64'(li), 64'd256);
    chk("t5_last_cnt", 64'(lc), 64'd1);
    chk("t5_data_errs", 64'(er), 64'd0);

    // asynchronous reset mid-packet
    m_ready = 1'b0;
    for (int w = 0; w < 9; w++) begin
      in_valid = 1'b1; in_data = mkword(16'h6000 + 16'(w*16));
      @(negedge clk);
    end
    in_valid = 1'b0; m_ready = 1'b1;
    repeat (6) @(negedge clk);
    held = m_data;
    chk("t6_pre_rst_beat", held, beatof(mkword(16'h6010), 2));
    chk("t6_pre_rst_ovf", 64'(overflow), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_valid", 64'(m_valid), 64'd0);
    chk("t6_data", m_data, 64'd0);
    chk("t6_last", 64'(m_last), 64'd0);
    chk("t6_overflow", 64'(overflow), 64'd0);
    chk("t6_level", 64'(fifo_level), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_packet(16'h0700, li, lc, ml, er, bt);
    chk("t6_last_idx", 64'(li), 64'd256);
    chk("t6_last_cnt", 64'(lc), 64'd1);
    chk("t6_data_errs", 64'(er), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wavelet_result_serializer.md
Name: wavelet_result_serializer

Overview:
- Sink-side companion to wavelet_baseline_removal_top: accepts its 16-lane, 256-bit result words (pulsed valid, no backpressure) and re-emits them as a narrower valid/ready stream toward DMA/AXI-Stream logic.
- Buffers words in a small FIFO, splits each word into LANES/OUT_LANES beats and marks packet boundaries with m_last.
- Flags lost data with a sticky overflow bit.

Parameters:
- DATA_WIDTH, 16, bits per sample lane.
- LANES, 16, samples per input word.
- OUT_LANES, 4, samples per output beat; LANES must be an integer multiple of it.
- FIFO_DEPTH, 8, input words buffered; power of 2, minimum 2.
- PKT_WORDS, 64, input words per output packet; minimum 1.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- clear  in  1  synchronous flush; 1-cycle pulse or level.
- in_valid  in  1  input word strobe; connects to baseline_valid.
- in_data  in  DATA_WIDTH*LANES  packed word; lane i at bits [DATA_WIDTH*(i+1)-1 : DATA_WIDTH*i].
- m_valid  out  1  output beat valid.
- m_ready  in  1  downstream ready.
- m_data  out  DATA_WIDTH*OUT_LANES  beat data; beat b carries lanes b*OUT_LANES to b*OUT_LANES+OUT_LANES-1, lowest lane in the LSBs.
- m_last  out  1  last beat of a packet.
- overflow  out  1  sticky word-drop flag.
- fifo_level  out  clog2(FIFO_DEPTH)+1  words currently stored.

Behaviour:
- Reset (rst_n low, asynchronous): FIFO empty, pointers/beat/word counters 0, m_valid=0, m_last=0, m_data=0, overflow=0, fifo_level=0. Reset mid-packet discards all state; the next packet starts fresh.
- Clock and reset: single clock domain; the only asynchronous input is rst_n.
- Push:
  - in_valid=1 writes in_data when level<FIFO_DEPTH, or when the head word pops in the same cycle (final beat handshakes).
  - Otherwise the word is dropped and overflow sets.
  - Dropped words do not advance the packet word counter.
- Latency: a word written at edge N has its beat 0 on m_data with m_valid=1 after edge N (1 cycle, empty FIFO).
- Output:
  - m_valid = (level!=0).
  - m_data = head word slice selected by beat counter bcnt (0..LANES/OUT_LANES-1).
  - m_data is 0 when m_valid=0.
- Handshake (m_valid & m_ready):
  - bcnt increments.
  - On the final beat, bcnt wraps to 0, the head pops and the word counter wcnt increments.
  - wcnt wraps to 0 after PKT_WORDS-1.
- m_last = m_valid & (bcnt==final beat) & (wcnt==PKT_WORDS-1).
- m_data and m_last hold stable while m_valid & !m_ready. m_valid never drops without a handshake, except on clear or reset.
- Simultaneous push and pop: level is unchanged. Full plus a final-beat pop plus a push is accepted without overflow.
- Wrap-around: read/write pointers are modulo FIFO_DEPTH. Full/empty are distinguished by the level counter, not by pointer equality.
- clear (sync): empties the FIFO, zeroes bcnt, wcnt and overflow. It has priority over push, so a coincident in_valid word is discarded and does not set overflow. m_valid=0 next cycle.
- overflow stays 1 until clear or reset.

Test Plan:
1. Single word, lane i = 16'h1000+i, m_ready=1 -> 4 consecutive beats:
   - m_data = {1003,1002,1001,1000}, {1007..1004}, {100B..1008}, {100F..100C};
   - m_valid rises 1 cycle after in_valid;
   - m_last=0 (PKT_WORDS=64).
2. 64 back-to-back words at in_valid 1-in-4 cycles, m_ready=1:
   - 256 beats;
   - m_last high exactly on beat 256 only;
   - overflow=0; fifo_level never exceeds 1.
3. m_ready=0, 9 words pushed continuously (FIFO_DEPTH=8):
   - fifo_level=8;
   - overflow=1 after word 9;
   - releasing m_ready yields words 1-8 in order, word 9 absent;
   - m_data stable throughout the stall.
4. FIFO full, in_valid coincides with the final-beat handshake of the head -> word accepted, fifo_level stays 8, overflow stays 0.
5. Mid-packet clear after 3 words + 2 beats consumed, in_valid=1 on the clear cycle:
   - next cycle m_valid=0, fifo_level=0, overflow=0;
   - next packet's m_last lands on its own 64th word.
6. rst_n asserted asynchronously mid-beat (between edges) -> all outputs 0 immediately. After release, the first new word emits beat 0 with bcnt=0 and wcnt=0.
